// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : State encoding, instruction field positions and ALU control
//               bit indices shared by the Hack CPU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int         c_STATE_W    = 2;
    localparam logic [1:0] c_S_FETCH    = 2'd0;
    localparam logic [1:0] c_S_DECODE   = 2'd1;
    localparam logic [1:0] c_S_MEM_WAIT = 2'd2;
    localparam logic [1:0] c_S_EXEC     = 2'd3;

    localparam int c_C_BIT   = 15;
    localparam int c_A_BIT   = 12;
    localparam int c_COMP_HI = 11;
    localparam int c_COMP_LO = 6;
    localparam int c_DEST_HI = 5;
    localparam int c_DEST_LO = 3;
    localparam int c_JUMP_HI = 2;
    localparam int c_JUMP_LO = 0;

    localparam int c_D1_BIT = 5;
    localparam int c_D2_BIT = 4;
    localparam int c_D3_BIT = 3;

    localparam int c_J_LT_BIT = 2;
    localparam int c_J_EQ_BIT = 1;
    localparam int c_J_GT_BIT = 0;

    localparam int c_ALU_ZX = 5;
    localparam int c_ALU_NX = 4;
    localparam int c_ALU_ZY = 3;
    localparam int c_ALU_NY = 2;
    localparam int c_ALU_F  = 1;
    localparam int c_ALU_NO = 0;

    function automatic logic [5:0] comp_field(input logic [15:0] ir);
        return ir[c_COMP_HI:c_COMP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_jump_eval.sv
`default_nettype none
// ============================================================================
// Module      : hack_jump_eval
// Description : Combinational jump decision from the ALU result and j1..j3.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_jump_eval
    import hack_pkg::*;
(
    input  logic [15:0] alu_out,
    input  logic [2:0]  jump_bits,
    output logic        jump
);

    logic w_zr;
    logic w_ng;

    assign w_zr = (alu_out == 16'h0000);
    assign w_ng = alu_out[15];

    assign jump = (jump_bits[c_J_LT_BIT] & w_ng)
                | (jump_bits[c_J_EQ_BIT] & w_zr)
                | (jump_bits[c_J_GT_BIT] & ~w_ng & ~w_zr);

endmodule
`default_nettype wire

// File: rtl/hack_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hack_control_unit
// Description : Multi-cycle Hack CPU sequencer owning A, D, IR and PC; drives
//               the external ALU and handshakes with instruction ROM / RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_control_unit
    import hack_pkg::*;
#(
    parameter int RESET_PC = 0,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_req,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    output logic [15:0]       alu_x,
    output logic [15:0]       alu_y,
    output logic [5:0]        alu_signal,
    input  logic [15:0]       alu_out,
    output logic              instr_done
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [15:0]          r_a;
    logic [15:0]          r_d;
    logic [15:0]          r_ir;
    logic [15:0]          r_m;
    logic                 w_jump;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    hack_jump_eval u_jump_eval (
        .alu_out   (alu_out),
        .jump_bits (r_ir[c_JUMP_HI:c_JUMP_LO]),
        .jump      (w_jump)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_FETCH:    if (instr_valid) w_next_state = c_S_DECODE;
            c_S_DECODE: begin
                if (!r_ir[c_C_BIT])      w_next_state = c_S_FETCH;
                else if (r_ir[c_A_BIT])  w_next_state = c_S_MEM_WAIT;
                else                     w_next_state = c_S_EXEC;
            end
            c_S_MEM_WAIT: if (mem_rvalid) w_next_state = c_S_EXEC;
            c_S_EXEC:     w_next_state = c_S_FETCH;
            default:      w_next_state = c_S_FETCH;
        endcase
    end

    always_comb begin
        instr_req  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            c_S_FETCH:    instr_req  = 1'b1;
            c_S_DECODE:   instr_done = ~r_ir[c_C_BIT];
            c_S_MEM_WAIT: mem_re     = 1'b1;
            c_S_EXEC: begin
                mem_we     = r_ir[c_D3_BIT];
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Jump target and write address both come from the pre-update A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_PC);
            r_a  <= 16'h0000;
            r_d  <= 16'h0000;
            r_ir <= 16'h0000;
            r_m  <= 16'h0000;
        end else begin
            case (r_state)
                c_S_FETCH: begin
                    if (instr_valid) r_ir <= instr;
                end
                c_S_DECODE: begin
                    if (!r_ir[c_C_BIT]) begin
                        r_a  <= {1'b0, r_ir[14:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                c_S_MEM_WAIT: begin
                    if (mem_rvalid) r_m <= mem_rdata;
                end
                c_S_EXEC: begin
                    if (r_ir[c_D1_BIT]) r_a <= alu_out;
                    if (r_ir[c_D2_BIT]) r_d <= alu_out;
                    r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign pc         = r_pc;
    assign mem_addr   = r_a[ADDR_W-1:0];
    assign mem_wdata  = alu_out;
    assign alu_x      = r_d;
    assign alu_y      = r_ir[c_A_BIT] ? r_m : r_a;
    assign alu_signal = comp_field(r_ir);

endmodule
`default_nettype wire
